// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command assembler
package uart_cmd_pkg;

  typedef enum logic [1:0] {IDLE, GOT_CMD, GOT_HI} asm_state_t;

  localparam int PKT_BYTES            = 3;
  localparam int DEFAULT_TIMEOUT_CLKS = 104160;

endpackage

// File: rtl/byte_timeout_timer.sv
// rtl/byte_timeout_timer.sv - saturating inter-byte gap counter
module byte_timeout_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  parameter int TMR_W        = $clog2(TIMEOUT_CLKS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CLKS - 1);

  logic [TMR_W-1:0] count;

  // Clear wins over run; the count parks at LAST instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - assembles 3-byte UART command packets for the command decoder
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  parameter int TMR_W        = $clog2(TIMEOUT_CLKS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);

  asm_state_t state, next_state;
  logic [7:0] cmd_shadow, hi_shadow;
  logic       take_cmd, take_hi, complete, timeout;
  logic       expired, tmr_clr, tmr_run;

  // Gap timer restarts on every accepted byte and on the drop back to IDLE.
  assign tmr_run = busy;
  assign tmr_clr = (state == IDLE) | rx_rdy | timeout;

  byte_timeout_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .TMR_W        (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expired (expired)
  );

  // Every offered byte is consumed in the cycle it is seen.
  assign clr_rx_rdy = rx_rdy & rst_n;
  assign busy       = (state != IDLE);

  // Next-state and per-cycle strobes; an arriving byte beats the timeout.
  always_comb begin
    next_state = state;
    take_cmd   = 1'b0;
    take_hi    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_rdy) begin
          take_cmd   = 1'b1;
          next_state = GOT_CMD;
        end
      end
      GOT_CMD: begin
        if (rx_rdy) begin
          take_hi    = 1'b1;
          next_state = GOT_HI;
        end else if (expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      GOT_HI: begin
        if (rx_rdy) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Partial-packet shadows for the command and data high bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_shadow <= 8'h00;
      hi_shadow  <= 8'h00;
    end else begin
      if (take_cmd) cmd_shadow <= rx_data;
      if (take_hi)  hi_shadow  <= rx_data;
    end
  end

  // Packet outputs, consumer handshake, overrun and frame error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= 8'h00;
      data      <= 16'h0000;
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (complete) begin
        cmd     <= cmd_shadow;
        data    <= {hi_shadow, rx_data};
        cmd_rdy <= 1'b1;
        if (cmd_rdy) overrun <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - self-checking bench for uart_cmd_assembler
module tb_uart_cmd_assembler;
  import uart_cmd_pkg::*;

  localparam int TO = 100;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        overrun;
  logic        frame_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_cmd_assembler #(.TIMEOUT_CLKS(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes gathered in a queue, timeout judged by the gap in cycles
  logic [7:0]  pkt[$];
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  logic        exp_cmd_rdy = 1'b0;
  logic [7:0]  exp_cmd = 8'h00;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_overrun = 1'b0;
  logic        exp_frame_err = 1'b0;
  int          exp_fe_cnt = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pkt.delete();
        exp_cmd_rdy   = 1'b0;
        exp_cmd       = 8'h00;
        exp_data      = 16'h0000;
        exp_overrun   = 1'b0;
        exp_frame_err = 1'b0;
      end else begin
        exp_frame_err = 1'b0;
        if (rx_rdy) begin
          pkt.push_back(rx_data);
          last_acc = cyc;
        end else if (pkt.size() != 0 && (cyc - last_acc) == TO) begin
          pkt.delete();
          exp_frame_err = 1'b1;
          exp_fe_cnt++;
        end
        if (pkt.size() == PKT_BYTES) begin
          if (exp_cmd_rdy) exp_overrun = 1'b1;
          exp_cmd     = pkt[0];
          exp_data    = {pkt[1], pkt[2]};
          exp_cmd_rdy = 1'b1;
          pkt.delete();
        end else if (clr_cmd_rdy) begin
          exp_cmd_rdy = 1'b0;
          exp_overrun = 1'b0;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, plus pulse counters
  int mism = 0;
  int clr_cnt = 0;
  int fe_cnt = 0;
  always @(negedge clk) begin
    if (cmd_rdy !== exp_cmd_rdy || cmd !== exp_cmd || data !== exp_data ||
        overrun !== exp_overrun || frame_err !== exp_frame_err ||
        busy !== (pkt.size() != 0) || clr_rx_rdy !== (rx_rdy && rst_n))
      mism <= mism + 1;
    if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;
    if (frame_err)  fe_cnt  <= fe_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_rdy = 1'b1;
    rx_data = 8'h5A;
    clr_cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (clr_rx_rdy !== 1'b0) begin failures++; $display("FAIL reset_clr_rx_rdy got=%b want=0", clr_rx_rdy); end
    rx_rdy = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL reset_cmd_rdy got=%b want=0", cmd_rdy); end
    checks++; if (cmd !== 8'h00 || data !== 16'h0000) begin failures++; $display("FAIL reset_cmd_data got=%h/%h want=00/0000", cmd, data); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b want=000", overrun, frame_err, busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int c0, f0;
    c0 = clr_cnt;
    f0 = fe_cnt;
    send_byte(8'h05);
    idle(20);
    send_byte(8'hA5);
    idle(20);
    send_byte(8'h3C);
    checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL basic_cmd_rdy got=%b want=1", cmd_rdy); end
    checks++; if (cmd !== 8'h05) begin failures++; $display("FAIL basic_cmd got=%h want=05", cmd); end
    checks++; if (data !== 16'hA53C) begin failures++; $display("FAIL basic_data got=%h want=a53c", data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b want=0", overrun); end
    checks++; if (clr_cnt - c0 != 3) begin failures++; $display("FAIL basic_clr_pulses got=%0d want=3", clr_cnt - c0); end
    checks++; if (fe_cnt != f0) begin failures++; $display("FAIL basic_frame_err got=%0d want=%0d", fe_cnt, f0); end
    checks++; if (mism != 0) begin failures++; $display("FAIL basic_model got=%0d want=0", mism); end
  endtask

  task automatic test_handshake();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL handshake_cmd_rdy got=%b want=0", cmd_rdy); end
    checks++; if (cmd !== 8'h05 || data !== 16'hA53C) begin failures++; $display("FAIL handshake_hold got=%h/%h want=05/a53c", cmd, data); end
  endtask

  task automatic test_timeout();
    int f0;
    f0 = fe_cnt;
    send_byte(8'h02);
    send_byte(8'h11);
    idle(TO);
    checks++; if (frame_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b/%b want=1/0", frame_err, busy); end
    tick();
    checks++; if (frame_err !== 1'b0 || fe_cnt - f0 != 1) begin failures++; $display("FAIL timeout_once got=%b/%0d want=0/1", frame_err, fe_cnt - f0); end
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL timeout_no_cmd got=%b want=0", cmd_rdy); end
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h01);
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h07 || data !== 16'h0001) begin failures++; $display("FAIL timeout_next got=%b/%h/%h want=1/07/0001", cmd_rdy, cmd, data); end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    int f0;
    f0 = fe_cnt;
    send_byte(8'h20);
    idle(TO - 1);
    send_byte(8'h21);
    checks++; if (frame_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL boundary_accept got=%b/%b want=0/1", frame_err, busy); end
    idle(TO - 1);
    send_byte(8'h22);
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h20 || data !== 16'h2122 || fe_cnt != f0) begin failures++; $display("FAIL boundary_pkt got=%b/%h/%h/%0d want=1/20/2122/%0d", cmd_rdy, cmd, data, fe_cnt, f0); end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_byte(8'h30);
    idle(TO);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    checks++; if (cmd !== 8'h31 || data !== 16'h3233 || fe_cnt - f0 != 1) begin failures++; $display("FAIL boundary_late got=%h/%h/%0d want=31/3233/1", cmd, data, fe_cnt - f0); end
    checks++; if (mism != 0) begin failures++; $display("FAIL boundary_model got=%0d want=0", mism); end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_overrun();
    send_byte(8'h01); send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h02); send_byte(8'h22); send_byte(8'h22);
    checks++; if (overrun !== 1'b1 || cmd !== 8'h02 || data !== 16'h2222) begin failures++; $display("FAIL overrun_set got=%b/%h/%h want=1/02/2222", overrun, cmd, data); end
    send_byte(8'h03); send_byte(8'h33);
    clr_cmd_rdy = 1'b1;
    send_byte(8'h44);
    clr_cmd_rdy = 1'b0;
    checks++; if (cmd_rdy !== 1'b1 || overrun !== 1'b1 || data !== 16'h3344) begin failures++; $display("FAIL overrun_coincide got=%b/%b/%h want=1/1/3344", cmd_rdy, overrun, data); end
    idle(3);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    checks++; if (cmd_rdy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b/%b want=0/0", cmd_rdy, overrun); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    send_byte(8'h64); send_byte(8'h65); send_byte(8'h66);
    send_byte(8'h09);
    send_byte(8'h44);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_flags got=%b%b%b want=000", cmd_rdy, overrun, busy); end
    checks++; if (cmd !== 8'h00 || data !== 16'h0000) begin failures++; $display("FAIL midreset_regs got=%h/%h want=00/0000", cmd, data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h0A || data !== 16'h0B0C || overrun !== 1'b0) begin failures++; $display("FAIL midreset_pkt got=%b/%h/%h/%b want=1/0a/0b0c/0", cmd_rdy, cmd, data, overrun); end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 250; i++) begin
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 4, TO + 4)) : int'($urandom_range(0, 4));
      for (int k = 0; k < gap; k++) begin
        clr_cmd_rdy = ($urandom_range(0, 5) == 0);
        tick();
      end
      clr_cmd_rdy = ($urandom_range(0, 5) == 0);
      send_byte(8'($urandom));
      clr_cmd_rdy = 1'b0;
    end
    idle(TO + 5);
    checks++; if (mism != 0) begin failures++; $display("FAIL random_model got=%0d want=0", mism); end
    checks++; if (cmd !== exp_cmd || data !== exp_data) begin failures++; $display("FAIL random_final got=%h/%h want=%h/%h", cmd, data, exp_cmd, exp_data); end
    checks++; if (fe_cnt != exp_fe_cnt) begin failures++; $display("FAIL random_frame_errs got=%0d want=%0d", fe_cnt, exp_fe_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_reset_mid();
    test_random();
    checks++; if (mism != 0) begin failures++; $display("FAIL overall_model got=%0d want=0", mism); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Controller that sequences the UART byte receiver. It consumes received bytes through the receiver's rdy/clr_rdy handshake and assembles 3-byte command packets: byte 0 is the command, byte 1 is data[15:8], byte 2 is data[7:0]. It presents each complete packet to the flight-control command decoder with a held cmd_rdy / clr_cmd_rdy handshake, and flags inter-byte timeouts and unconsumed-packet overruns.

Parameters:
TIMEOUT_CLKS, 104160, maximum clocks allowed between accepted bytes of one packet (about 4 byte times at 19200 baud on a 50 MHz clock); must be >= 2.
TMR_W, $clog2(TIMEOUT_CLKS), width of the timeout counter.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  receiver has a byte available; held high until cleared
rx_data  input  8  received byte; valid while rx_rdy=1
clr_rx_rdy  output  1  combinational; consumes the current byte; receiver drops rx_rdy the following cycle
clr_cmd_rdy  input  1  consumer has taken the packet; clears cmd_rdy
cmd_rdy  output  1  complete packet held on cmd/data
cmd  output  8  command byte of the last complete packet
data  output  16  data word of the last complete packet, high byte first on the wire
overrun  output  1  sticky; a packet completed while cmd_rdy was still 1
frame_err  output  1  one-cycle pulse; a partial packet was discarded on timeout
busy  output  1  1 while in states GOT_CMD or GOT_HI

Behaviour:
- Reset is asynchronous, active low, on rst_n with clock clk.
  - On reset: state=IDLE, cmd_rdy=0, cmd=8'h00, data=16'h0000, overrun=0, frame_err=0, timer=0.
  - Reset mid-packet discards all partial bytes.
- clr_rx_rdy=1 in every cycle where rx_rdy=1 and the FSM is not in reset. Every offered byte is consumed exactly once.
  - The FSM advances on the same clock edge.
  - Because rx_rdy drops one cycle after clr_rx_rdy, one byte is never counted twice.
- FSM states are IDLE, GOT_CMD and GOT_HI:
  - IDLE: on rx_rdy, capture rx_data into cmd_shadow, clear timer, go to GOT_CMD.
  - GOT_CMD: on rx_rdy, capture into hi_shadow, clear timer, go to GOT_HI.
  - GOT_CMD: else, if timer==TIMEOUT_CLKS-1, go to IDLE and pulse frame_err for one cycle.
  - GOT_CMD: otherwise timer++.
  - GOT_HI: on rx_rdy, go to IDLE.
    - On that edge: cmd<=cmd_shadow, data<={hi_shadow, rx_data}, cmd_rdy<=1.
    - overrun<=1 if cmd_rdy was already 1.
  - GOT_HI: timeout is handled as in GOT_CMD.
- Latency: cmd_rdy rises on the clock edge that consumes byte 2, i.e. one cycle after rx_rdy is first seen for that byte.
- cmd and data change only on a packet-completion edge. They are stable at all other times, including while cmd_rdy=0.
- cmd_rdy clear: clr_cmd_rdy=1 clears cmd_rdy on the next edge. If clr_cmd_rdy coincides with a completion edge, the set wins (cmd_rdy=1).
- overrun clear: clr_cmd_rdy without a coincident completion clears overrun. A completion with cmd_rdy=1 sets overrun even if clr_cmd_rdy is high in that cycle.
- Timeout priority: if rx_rdy=1 in the same cycle the timer reaches TIMEOUT_CLKS-1, the byte is accepted and no frame_err is raised.
- Timer behaviour: the timer runs only in GOT_CMD and GOT_HI and is held at 0 in IDLE, so there is no free-running count. It saturates; it never wraps.
- A frame_err pulse and a new byte arriving in the next cycle are independent. That byte starts a fresh packet as the command byte.
- busy is combinational from state.

Decomposition:
- Package uart_cmd_pkg holds:
  - typedef enum logic [1:0] {IDLE, GOT_CMD, GOT_HI} asm_state_t;
  - localparam PKT_BYTES=3;
  - localparam DEFAULT_TIMEOUT_CLKS=104160.
- One sub-module, byte_timeout_timer. It takes clk, rst_n, clr, run and a TIMEOUT_CLKS parameter, and outputs expired. It is a saturating up-counter. The assembler instantiates it and keeps the FSM, the shadow registers and the output registers itself.

Test Plan:
- Run all scenarios with TIMEOUT_CLKS=100, driving the receiver interface from a bench model.
- Basic packet: send bytes 8'h05, 8'hA5, 8'h3C with 20 idle cycles between them.
  - Required: exactly 3 single-cycle clr_rx_rdy pulses.
  - Required: cmd_rdy=1 one cycle after the third rx_rdy, with cmd=8'h05 and data=16'hA53C.
  - Required: overrun=0, frame_err never pulses.
- Consumer handshake: with cmd_rdy=1, pulse clr_cmd_rdy.
  - Required: cmd_rdy=0 next cycle; cmd and data still read 8'h05 and 16'hA53C.
- Timeout: send 8'h02, 8'h11, then wait 100 cycles.
  - Required: one frame_err pulse, state back to IDLE, no cmd_rdy.
  - Follow with 8'h07, 8'h00, 8'h01. Required: cmd=8'h07, data=16'h0001.
- Timeout boundary: deliver byte 1 exactly on the cycle the timer reaches 99.
  - Required: the byte is accepted and frame_err=0.
- Overrun: complete two packets (8'h01 / 16'h1111, then 8'h02 / 16'h2222) without clr_cmd_rdy.
  - Required: overrun=1, cmd=8'h02, data=16'h2222.
  - Then, with clr_cmd_rdy asserted on the completion edge of a third packet: cmd_rdy=1 and overrun stays 1. A later clr_cmd_rdy with no completion clears both.
- Reset mid-packet: send 8'h09, 8'h44, then assert rst_n=0 asynchronously.
  - Required: all outputs go to their reset values immediately.
  - After release, 3 new bytes produce a correct packet with no stale bytes.
